// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-only bus between the sample reader (master) and the flash
// controller (slave).
interface flash_sample_reader_if;
  logic        flash_read;
  logic [22:0] flash_address;
  logic [3:0]  flash_byteenable;
  logic        flash_waitrequest;
  logic [31:0] flash_readdata;
  logic        flash_readdatavalid;

  modport master (
    output flash_read, flash_address, flash_byteenable,
    input  flash_waitrequest, flash_readdata, flash_readdatavalid
  );

  modport slave (
    input  flash_read, flash_address, flash_byteenable,
    output flash_waitrequest, flash_readdata, flash_readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit flash word per address strobe and plays it out as two
// 16-bit audio samples on consecutive sample-rate strobes.
module flash_sample_reader (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [22:0]                   start_addr,
  input  logic                          addr_valid,
  input  logic                          edge_trigger,
  input  logic                          direction,
  flash_sample_reader_if.master         flash,
  output logic [15:0]                   sample,
  output logic                          sample_valid,
  output logic                          fetch_done,
  output logic                          busy,
  output logic [7:0]                    underrun_cnt
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT_DATA, EDGE1, EDGE2, DONE} state_t;

  state_t      state_q, state_d;
  logic [22:0] addr_q;
  logic [31:0] word_q;
  logic        dir_q;

  logic accept, capture, emit1, emit2, underrun;

  // A read may complete in the same cycle the request is accepted.
  assign accept   = (state_q == REQ) && !flash.flash_waitrequest;
  assign capture  = (accept || (state_q == WAIT_DATA)) && flash.flash_readdatavalid;
  assign emit1    = (state_q == EDGE1) && edge_trigger;
  assign emit2    = (state_q == EDGE2) && edge_trigger;
  assign underrun = ((state_q == REQ) || (state_q == WAIT_DATA)) && edge_trigger;

  // Bus outputs follow state directly so reset drops the read at once.
  assign flash.flash_read       = (state_q == REQ);
  assign flash.flash_address    = addr_q;
  assign flash.flash_byteenable = 4'hF;
  assign busy                   = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (addr_valid) state_d = REQ;
      REQ:       if (capture) state_d = EDGE1;
                 else if (accept) state_d = WAIT_DATA;
      WAIT_DATA: if (capture) state_d = EDGE1;
      EDGE1:     if (edge_trigger) state_d = EDGE2;
      EDGE2:     if (edge_trigger) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: address latch, word capture, sample playout, strobes, underruns.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      word_q       <= '0;
      dir_q        <= 1'b0;
      sample       <= '0;
      sample_valid <= 1'b0;
      fetch_done   <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if ((state_q == IDLE) && addr_valid) addr_q <= start_addr;
      if (capture) word_q <= flash.flash_readdata;
      sample_valid <= emit1 || emit2;
      // fetch_done lands the cycle after DONE, so it never meets the
      // second sample_valid, which lands in DONE itself.
      fetch_done   <= (state_q == DONE);
      if (emit1) begin
        dir_q  <= direction;
        sample <= direction ? word_q[31:16] : word_q[15:0];
      end
      if (emit2) sample <= dir_q ? word_q[15:0] : word_q[31:16];
      if (underrun && (underrun_cnt != 8'd255)) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader.
module tb_flash_sample_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [22:0] start_addr = '0;
  logic        addr_valid = 1'b0;
  logic        edge_trigger = 1'b0;
  logic        direction = 1'b0;
  logic [15:0] sample;
  logic        sample_valid, fetch_done, busy;
  logic [7:0]  underrun_cnt;

  int tests = 0;
  int fails = 0;

  flash_sample_reader_if fbus ();

  flash_sample_reader dut (
    .clk(clk), .rst(rst), .start_addr(start_addr), .addr_valid(addr_valid),
    .edge_trigger(edge_trigger), .direction(direction), .flash(fbus),
    .sample(sample), .sample_valid(sample_valid), .fetch_done(fetch_done),
    .busy(busy), .underrun_cnt(underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Stimulus helpers (no checking): issue an address, and supply read data.
  task automatic issue(input logic [22:0] a);
    start_addr = a; addr_valid = 1'b1; tick(); addr_valid = 1'b0;
  endtask

  task automatic give_data(input logic [31:0] d);
    fbus.flash_readdata = d; fbus.flash_readdatavalid = 1'b1; tick();
    fbus.flash_readdatavalid = 1'b0;
  endtask

  task automatic pulse_edge();
    edge_trigger = 1'b1; tick(); edge_trigger = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; #3; rst = 1'b0; tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; #3;
    tests++; if (fbus.flash_read !== 1'b0) begin fails++; $display("FAIL reset_read got %b exp 0", fbus.flash_read); end
    tests++; if (fbus.flash_address !== 23'h0) begin fails++; $display("FAIL reset_addr got %h exp 0", fbus.flash_address); end
    tests++; if (fbus.flash_byteenable !== 4'hF) begin fails++; $display("FAIL reset_be got %h exp F", fbus.flash_byteenable); end
    tests++; if ({sample, sample_valid, fetch_done, busy, underrun_cnt} !== 27'h0) begin fails++;
      $display("FAIL reset_outs got s=%h sv=%b fd=%b b=%b u=%0d exp all 0", sample, sample_valid, fetch_done, busy, underrun_cnt); end
    rst = 1'b0; tick();
  endtask

  task automatic test_forward();
    issue(23'h000010);
    tests++; if (fbus.flash_read !== 1'b1 || fbus.flash_address !== 23'h10) begin fails++;
      $display("FAIL fwd_req got rd=%b a=%h exp 1/000010", fbus.flash_read, fbus.flash_address); end
    tick();
    tests++; if (fbus.flash_read !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL fwd_wait got rd=%b busy=%b exp 0/1", fbus.flash_read, busy); end
    give_data(32'hAAAA5555);
    direction = 1'b0; pulse_edge();
    tests++; if (sample_valid !== 1'b1 || sample !== 16'h5555) begin fails++;
      $display("FAIL fwd_s0 got sv=%b s=%h exp 1/5555", sample_valid, sample); end
    tick();
    tests++; if (sample_valid !== 1'b0 || sample !== 16'h5555) begin fails++;
      $display("FAIL fwd_hold got sv=%b s=%h exp 0/5555", sample_valid, sample); end
    pulse_edge();
    tests++; if (sample_valid !== 1'b1 || sample !== 16'hAAAA || fetch_done !== 1'b0) begin fails++;
      $display("FAIL fwd_s1 got sv=%b s=%h fd=%b exp 1/AAAA/0", sample_valid, sample, fetch_done); end
    tick();
    tests++; if (fetch_done !== 1'b1 || sample_valid !== 1'b0 || busy !== 1'b0) begin fails++;
      $display("FAIL fwd_done got fd=%b sv=%b busy=%b exp 1/0/0", fetch_done, sample_valid, busy); end
    tick();
    tests++; if (fetch_done !== 1'b0) begin fails++; $display("FAIL fwd_done_once got %b exp 0", fetch_done); end
  endtask

  task automatic test_backward();
    issue(23'h000010); tick();
    give_data(32'hAAAA5555);
    direction = 1'b1; pulse_edge();
    tests++; if (sample !== 16'hAAAA) begin fails++; $display("FAIL bwd_s0 got %h exp AAAA", sample); end
    direction = 1'b0; pulse_edge();  // direction held from EDGE1
    tests++; if (sample !== 16'h5555 || sample_valid !== 1'b1) begin fails++;
      $display("FAIL bwd_s1 got s=%h sv=%b exp 5555/1", sample, sample_valid); end
    tick(); tick();
  endtask

  task automatic test_latency();
    int n;
    issue(23'h000020);                      // edge 1
    fbus.flash_readdata = 32'h1234ABCD; fbus.flash_readdatavalid = 1'b1;
    tick(); fbus.flash_readdatavalid = 1'b0; // edge 2: accept + capture
    tests++; if (fbus.flash_read !== 1'b0 || busy !== 1'b1) begin fails++;
      $display("FAIL lat_edge1 got rd=%b busy=%b exp 0/1", fbus.flash_read, busy); end
    pulse_edge();                            // edge 3
    tests++; if (sample_valid !== 1'b1 || sample !== 16'hABCD) begin fails++;
      $display("FAIL lat_sample got sv=%b s=%h exp 1/ABCD", sample_valid, sample); end
    pulse_edge();
    tests++; if (sample !== 16'h1234) begin fails++; $display("FAIL lat_s1 got %h exp 1234", sample); end
    n = 0;
    for (int i = 0; i < 3; i++) begin tick(); if (fetch_done) n++; end
    tests++; if (n != 1) begin fails++; $display("FAIL lat_done_cnt got %0d exp 1", n); end
  endtask

  task automatic test_stall();
    int hi, bad;
    hi = 0; bad = 0;
    issue(23'h000010);
    fbus.flash_waitrequest = 1'b1;
    if (fbus.flash_read) hi++;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (fbus.flash_read) hi++;
      if (fbus.flash_address !== 23'h10) bad++;
    end
    fbus.flash_waitrequest = 1'b0; tick();
    if (fbus.flash_read) hi++;
    tests++; if (hi != 6) begin fails++; $display("FAIL stall_read_cycles got %0d exp 6", hi); end
    tests++; if (bad != 0) begin fails++; $display("FAIL stall_addr_unstable got %0d exp 0", bad); end
    give_data(32'h0); pulse_edge(); pulse_edge(); tick(); tick();
  endtask

  task automatic test_underrun();
    int sv;
    apply_reset();
    sv = 0;
    pulse_edge(); // IDLE: ignored
    tests++; if (underrun_cnt !== 8'd0) begin fails++; $display("FAIL idle_edge got %0d exp 0", underrun_cnt); end
    issue(23'h000030); tick();
    for (int i = 0; i < 3; i++) begin pulse_edge(); if (sample_valid) sv++; tick(); if (sample_valid) sv++; end
    tests++; if (underrun_cnt !== 8'd3 || sv != 0) begin fails++;
      $display("FAIL underrun3 got cnt=%0d sv=%0d exp 3/0", underrun_cnt, sv); end
    give_data(32'h0); pulse_edge(); pulse_edge();
    pulse_edge(); // DONE: ignored
    tests++; if (underrun_cnt !== 8'd3) begin fails++; $display("FAIL done_edge got %0d exp 3", underrun_cnt); end
    tick();
    issue(23'h000040);
    fbus.flash_waitrequest = 1'b1; edge_trigger = 1'b1;
    for (int i = 0; i < 300; i++) tick();
    edge_trigger = 1'b0; fbus.flash_waitrequest = 1'b0;
    tests++; if (underrun_cnt !== 8'd255) begin fails++; $display("FAIL underrun_sat got %0d exp 255", underrun_cnt); end
    apply_reset();
  endtask

  task automatic test_reset_mid_read();
    issue(23'h000050); tick();   // now WAIT_DATA
    rst = 1'b1; #2;
    tests++; if (fbus.flash_read !== 1'b0 || busy !== 1'b0 || fbus.flash_byteenable !== 4'hF) begin fails++;
      $display("FAIL midrst_async got rd=%b busy=%b be=%h exp 0/0/F", fbus.flash_read, busy, fbus.flash_byteenable); end
    rst = 1'b0; @(negedge clk);
    fbus.flash_readdata = 32'hDEADBEEF; fbus.flash_readdatavalid = 1'b1;
    tick(); fbus.flash_readdatavalid = 1'b0;
    pulse_edge();
    tests++; if (busy !== 1'b0 || sample_valid !== 1'b0 || sample !== 16'h0) begin fails++;
      $display("FAIL midrst_ignore got busy=%b sv=%b s=%h exp 0/0/0000", busy, sample_valid, sample); end
  endtask

  task automatic test_addr_ignored();
    issue(23'h000010); tick(); give_data(32'hCAFEF00D);  // EDGE1
    start_addr = 23'h7FFFFF; addr_valid = 1'b1; tick(); addr_valid = 1'b0;
    tests++; if (fbus.flash_address !== 23'h10) begin fails++;
      $display("FAIL addr_ignored got %h exp 000010", fbus.flash_address); end
    direction = 1'b0; pulse_edge(); pulse_edge(); tick();
    tests++; if (fetch_done !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL addr_ign_done got fd=%b busy=%b exp 1/0", fetch_done, busy); end
    issue(23'h000024);
    tests++; if (fbus.flash_address !== 23'h24 || fbus.flash_read !== 1'b1) begin fails++;
      $display("FAIL next_addr got a=%h rd=%b exp 000024/1", fbus.flash_address, fbus.flash_read); end
    tick(); give_data(32'h0); pulse_edge(); pulse_edge(); tick(); tick();
  endtask

  initial begin
    fbus.flash_waitrequest = 1'b0;
    fbus.flash_readdata = '0;
    fbus.flash_readdatavalid = 1'b0;
    #1;
    test_reset();
    test_forward();
    test_backward();
    test_latency();
    test_stall();
    test_underrun();
    test_reset_mid_read();
    test_addr_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flash_sample_reader.md
FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start_addr  in  23  flash word address from the address handler.
- addr_valid  in  1  one-cycle strobe; start_addr is valid.
- edge_trigger  in  1  one-cycle, clk-synchronous sample-rate strobe.
- direction  in  1  0 = forward (low half first), 1 = backward (high half first).
- flash_read  out  1  Avalon-MM read request.
- flash_address  out  23  Avalon-MM word address.
- flash_byteenable  out  4  constant 4'hF.
- flash_waitrequest  in  1  slave stall.
- flash_readdata  in  32  read data.
- flash_readdatavalid  in  1  read data valid.
- sample  out  16  current audio sample.
- sample_valid  out  1  one-cycle strobe; sample updated this cycle.
- fetch_done  out  1  one-cycle strobe; word fully consumed, next address requested.
- busy  out  1  high in every state except IDLE.
- underrun_cnt  out  8  saturating count of missed edge_trigger strobes.

Function
REQ-002 States SHALL be IDLE, REQ, WAIT_DATA, EDGE1, EDGE2, DONE.
REQ-003 IDLE: on addr_valid=1, latch start_addr into flash_address and go to REQ; otherwise stay.
REQ-004 addr_valid outside IDLE SHALL be ignored.
REQ-005 REQ: flash_read=1; stay while flash_waitrequest=1; when flash_waitrequest=0, go to WAIT_DATA (flash_read=0 from the next cycle).
REQ-006 If flash_readdatavalid=1 in the REQ acceptance cycle, the block SHALL capture the data and go directly to EDGE1.
REQ-007 WAIT_DATA: on flash_readdatavalid=1, capture flash_readdata into a 32-bit word register and go to EDGE1; no timeout.
REQ-008 EDGE1: on edge_trigger=1, sample SHALL be word[15:0] if direction=0, else word[31:16]; sample_valid=1 for that cycle; go to EDGE2.
REQ-009 EDGE2: on edge_trigger=1, sample SHALL be the other half; sample_valid=1; go to DONE.
REQ-010 direction SHALL be sampled in EDGE1 and held for EDGE2 of the same word.
REQ-011 DONE: fetch_done=1 for exactly one cycle, then IDLE unconditionally.
REQ-012 sample SHALL hold its last value between sample_valid strobes.
REQ-013 edge_trigger in REQ or WAIT_DATA SHALL increment underrun_cnt, saturating at 8'd255; no sample is emitted.
REQ-014 edge_trigger in IDLE or DONE SHALL be ignored and SHALL NOT count as an underrun.
REQ-015 sample_valid and fetch_done SHALL never be asserted in the same cycle.
REQ-016 Best-case latency: addr_valid to first sample_valid is 3 cycles plus the edge_trigger wait, with zero waitrequest and readdatavalid in the acceptance cycle.

Reset
REQ-017 While rst=1, asynchronously and independent of clk, the block SHALL set:
- state to IDLE;
- flash_read=0, flash_address=0;
- sample=0, sample_valid=0, fetch_done=0, busy=0;
- underrun_cnt=0;
- the word register to 0.
REQ-018 Reset asserted mid-transaction SHALL drop flash_read immediately; a flash_readdatavalid arriving after reset release SHALL be ignored.
REQ-019 flash_byteenable SHALL be 4'hF at all times, including during reset.

Verification
REQ-020 Forward read:
- stimulus: start_addr=23'h000010, addr_valid pulse, waitrequest=0, readdatavalid with 32'hAAAA5555 one cycle later, two edge_triggers;
- response: sample 16'h5555 then 16'hAAAA, then one fetch_done.
REQ-021 Backward read, same stimulus with direction=1: sample 16'hAAAA then 16'h5555.
REQ-022 Stall: waitrequest=1 for 5 cycles -> flash_read high for 6 cycles with flash_address stable at 23'h000010.
REQ-023 Underrun:
- 3 edge_triggers during WAIT_DATA -> underrun_cnt=3, no sample_valid;
- 300 underruns -> underrun_cnt=255.
REQ-024 Reset mid-read: rst pulsed in WAIT_DATA, then readdatavalid=1 -> flash_read=0 immediately, state IDLE, sample_valid stays 0.
REQ-025 addr_valid during EDGE1 with start_addr=23'h7FFFFF -> flash_address unchanged; the next fetch uses only an address presented after fetch_done.
